// File: rtl/store_checker.sv
// Store monitor: logs core stores, decides pass/fail on result address.
// Optional watchdog enabled by `define STORE_CHECKER_TIMEOUT_EN.
//
// Ports:
//   clk, rst (async, active-low)
//   w_en, rw_addr, w     : snooped store port
//   rd_en                : pop log head
//   log_valid/addr/data  : show-ahead log head
//   overflow             : sticky, a store was dropped
//   done, pass, fail     : verdict decode
//   timeout              : failure came from watchdog
//   cycles               : saturating RUN cycle count
module store_checker #(
  parameter int          DEPTH       = 4,
  parameter logic [7:0]  TARGET_ADDR = 8'd255,
  parameter logic [7:0]  EXPECT_DATA = 8'd13,
  parameter logic [15:0] TIMEOUT     = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en,
  input  logic [7:0]  rw_addr,
  input  logic [7:0]  w,
  input  logic        rd_en,
  output logic        log_valid,
  output logic [7:0]  log_addr,
  output logic [7:0]  log_data,
  output logic        overflow,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [15:0] cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  state_t state_q;
  state_t state_d;

  logic        run;
  logic        hit;
  logic [15:0] cycles_q;
  logic        overflow_q;

  assign run = (state_q == RUN);
  assign hit = w_en && (rw_addr == TARGET_ADDR);

  // cycle counter: counts every RUN edge, saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q <= '0;
    end else if (run && cycles_q != 16'hFFFF) begin
      cycles_q <= cycles_q + 16'd1;
    end
  end

`ifdef STORE_CHECKER_TIMEOUT_EN
  logic wd_fire;
  logic timeout_q;

  // fires on the edge that takes cycles to TIMEOUT
  assign wd_fire = (cycles_q == TIMEOUT - 16'd1);

  // a target store on the same edge wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_q <= 1'b0;
    end else if (run && !hit && wd_fire) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic wd_fire;
  logic unused_timeout;

  assign wd_fire        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (hit) begin
          state_d = (w == EXPECT_DATA) ? PASS : FAIL;
        end else if (wd_fire) begin
          state_d = FAIL;
        end
      end
      PASS: state_d = PASS;
      FAIL: state_d = FAIL;
      default: state_d = RUN;
    endcase
  end

  assign done = (state_q == PASS) || (state_q == FAIL);
  assign pass = (state_q == PASS);
  assign fail = (state_q == FAIL);

  // log FIFO
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          drop;

  assign full     = (count == FULL_C);
  assign pop      = rd_en && (count != '0);
  assign push_req = run && w_en;
  // a pop on the same edge frees the slot for the push
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= '{addr: rw_addr, data: w};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign log_valid = (count != '0);
  assign log_addr  = mem[rd_ptr].addr;
  assign log_data  = mem[rd_ptr].data;
  assign overflow  = overflow_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker with a queue-based reference model.
// Follows STORE_CHECKER_TIMEOUT_EN the same way as the design.
module tb_store_checker;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;
`ifdef STORE_CHECKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        w_en;
  logic [7:0]  rw_addr;
  logic [7:0]  w;
  logic        rd_en;
  logic        log_valid;
  logic [7:0]  log_addr;
  logic [7:0]  log_data;
  logic        overflow;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [15:0] cycles;

  int total = 0;
  int bad   = 0;

  store_checker #(
    .DEPTH      (DEPTH),
    .TARGET_ADDR(8'd255),
    .EXPECT_DATA(8'd13),
    .TIMEOUT    (16'(TIMEOUT))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .rw_addr  (rw_addr),
    .w        (w),
    .rd_en    (rd_en),
    .log_valid(log_valid),
    .log_addr (log_addr),
    .log_data (log_data),
    .overflow (overflow),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout),
    .cycles   (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act,
                       input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // reference model: 0 = running, 1 = passed, 2 = failed
  logic [15:0] mq[$];
  int          m_state;
  int          m_cyc;
  bit          m_ovf;
  bit          m_to;
  int          oc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_state = 0;
      m_cyc   = 0;
      m_ovf   = 1'b0;
      m_to    = 1'b0;
    end else begin
      oc = m_cyc;
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
      if (m_state == 0) begin
        if (w_en) begin
          if (mq.size() < DEPTH) mq.push_back({rw_addr, w});
          else m_ovf = 1'b1;
        end
        if (m_cyc < 65535) m_cyc++;
        if (w_en && rw_addr == 8'd255) begin
          m_state = (w == 8'd13) ? 1 : 2;
        end else if (TO_EN && oc == TIMEOUT - 1) begin
          m_state = 2;
          m_to    = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("m_valid", int'(log_valid), int'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("m_addr", int'(log_addr), int'(mq[0][15:8]));
        check("m_data", int'(log_data), int'(mq[0][7:0]));
      end
      check("m_ovf", int'(overflow), int'(m_ovf));
      check("m_done", int'(done), int'(m_state != 0));
      check("m_pass", int'(pass), int'(m_state == 1));
      check("m_fail", int'(fail), int'(m_state == 2));
      check("m_to", int'(timeout), int'(m_to));
      check("m_cyc", int'(cycles), m_cyc);
    end
  end

  // drive one cycle from a negedge; returns after the next negedge
  task automatic cyc(input logic we, input logic [7:0] a,
                     input logic [7:0] d, input logic r);
    w_en    = we;
    rw_addr = a;
    w       = d;
    rd_en   = r;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'd0, 8'd0, 1'b1);
  endtask

  task automatic head(input string nm, input int a, input int d);
    check({nm, "_v"}, int'(log_valid), 1);
    check({nm, "_a"}, int'(log_addr), a);
    check({nm, "_d"}, int'(log_data), d);
  endtask

  task automatic do_reset();
    w_en    = 1'b0;
    rw_addr = 8'd0;
    w       = 8'd0;
    rd_en   = 1'b0;
    rst     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic all_zero(input string nm);
    check({nm, "_valid"}, int'(log_valid), 0);
    check({nm, "_addr"}, int'(log_addr), 0);
    check({nm, "_data"}, int'(log_data), 0);
    check({nm, "_ovf"}, int'(overflow), 0);
    check({nm, "_done"}, int'(done), 0);
    check({nm, "_pass"}, int'(pass), 0);
    check({nm, "_fail"}, int'(fail), 0);
    check({nm, "_to"}, int'(timeout), 0);
    check({nm, "_cyc"}, int'(cycles), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst     = 1'b0;
    w_en    = 1'b0;
    rw_addr = 8'd0;
    w       = 8'd0;
    rd_en   = 1'b0;
    #1;
    all_zero("rst");
    @(negedge clk);
    do_reset();

    // pass at the fifth RUN edge
    repeat (4) idle();
    cyc(1'b1, 8'd255, 8'd13, 1'b0);
    check("p_done", int'(done), 1);
    check("p_pass", int'(pass), 1);
    check("p_fail", int'(fail), 0);
    head("p_head", 255, 13);
    check("p_cyc", int'(cycles), 5);
    repeat (3) idle();
    check("p_frozen", int'(cycles), 5);

    // fail, then drain in order
    do_reset();
    cyc(1'b1, 8'd10, 8'd1, 1'b0);
    cyc(1'b1, 8'd11, 8'd2, 1'b0);
    cyc(1'b1, 8'd255, 8'd7, 1'b0);
    check("f_fail", int'(fail), 1);
    check("f_pass", int'(pass), 0);
    check("f_to", int'(timeout), 0);
    head("f_h0", 10, 1);
    pop();
    head("f_h1", 11, 2);
    pop();
    head("f_h2", 255, 7);
    pop();
    check("f_empty", int'(log_valid), 0);
    pop();
    check("f_empty2", int'(log_valid), 0);

    // overflow, target dropped but verdict still taken
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'(40 + i), 8'(i), 1'b0);
    end
    check("o_ovf", int'(overflow), 1);
    head("o_head", 40, 0);
    cyc(1'b1, 8'd255, 8'd13, 1'b0);
    check("o_pass", int'(pass), 1);
    check("o_ovf2", int'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      head("o_drain", 40 + i, i);
      pop();
    end
    check("o_notgt", int'(log_valid), 0);

    // full fifo with push and pop together
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(20 + i), 8'(i + 100), 1'b0);
    end
    cyc(1'b1, 8'd24, 8'd104, 1'b1);
    check("pp_ovf", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      head("pp_drain", 21 + i, 101 + i);
      pop();
    end
    check("pp_empty", int'(log_valid), 0);

    // watchdog
    do_reset();
    repeat (19) idle();
    check("t_done19", int'(done), 0);
    check("t_cyc19", int'(cycles), 19);
    idle();
`ifdef STORE_CHECKER_TIMEOUT_EN
    check("t_fail", int'(fail), 1);
    check("t_to", int'(timeout), 1);
    check("t_cyc", int'(cycles), 20);
`else
    check("t_done", int'(done), 0);
    check("t_to", int'(timeout), 0);
    check("t_cyc", int'(cycles), 20);
`endif
    repeat (80) idle();
`ifdef STORE_CHECKER_TIMEOUT_EN
    check("t_cyc100", int'(cycles), 20);
`else
    check("t_done100", int'(done), 0);
    check("t_cyc100", int'(cycles), 100);
`endif

    // asynchronous reset mid-run
    do_reset();
    cyc(1'b1, 8'd30, 8'd3, 1'b0);
    cyc(1'b1, 8'd31, 8'd4, 1'b0);
    cyc(1'b1, 8'd32, 8'd5, 1'b0);
    head("a_pre", 30, 3);
    #2 rst = 1'b0;
    #1;
    all_zero("arst");
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 8'd255, 8'd13, 1'b0);
    check("a_pass", int'(pass), 1);
    check("a_cyc", int'(cycles), 1);
    head("a_head", 255, 13);
    pop();
    check("a_only", int'(log_valid), 0);

    // target store on the watchdog edge; later stores ignored
    do_reset();
    repeat (19) idle();
    cyc(1'b1, 8'd255, 8'd13, 1'b0);
    check("c_pass", int'(pass), 1);
    check("c_to", int'(timeout), 0);
    check("c_cyc", int'(cycles), 20);
    cyc(1'b1, 8'd255, 8'd7, 1'b0);
    cyc(1'b1, 8'd255, 8'd0, 1'b0);
    check("c_pass2", int'(pass), 1);
    check("c_fail2", int'(fail), 0);
    head("c_head", 255, 13);
    pop();
    check("c_nolog", int'(log_valid), 0);
    check("c_ovf", int'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
